// File: rtl/neuron_mac_if.sv
// Stream interface between the pixel/weight streamer, the neuron MAC and the
// layer output collector. The master modport is the streamer/collector side.
interface neuron_mac_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic signed [DATA_W-1:0] in_weight;
  logic                     in_last;
  logic signed [DATA_W-1:0] bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;
  logic                     frame_err;

  modport master (
    output in_valid, in_data, in_weight, in_last, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_weight, in_last, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat, frame_err
  );
endinterface

// File: rtl/neuron_mac.sv
// Fixed-point neuron: accumulates N_INPUTS data*weight products, adds a bias,
// truncates toward zero to Q.FRAC_W, optional ReLU, then saturates to DATA_W.
module neuron_mac #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int N_INPUTS = 784,
  parameter int ACC_W    = 40,
  parameter int RELU_EN  = 1
) (
  input logic         clk,
  input logic         reset,
  neuron_mac_if.slave bus
);
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic                     out_valid_q, out_valid_d;
  logic                     frame_err_q, frame_err_d;

  logic                       beat;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_sh;
  logic signed [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]           mag_sh;
  logic signed [ACC_W-1:0]    r_trunc;
  logic signed [ACC_W-1:0]    r_relu;
  logic signed [DATA_W-1:0]   sat_data;
  logic                       sat_flag;

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.frame_err = frame_err_q;

  assign beat     = bus.in_valid & bus.in_ready;
  assign prod     = bus.in_data * bus.in_weight;
  assign prod_ext = ACC_W'(prod);
  assign bias_sh  = ACC_W'(bus.bias) <<< FRAC_W;
  assign sum      = acc_q + bias_sh;

  // Shift the magnitude rather than the signed sum so the fraction is dropped
  // toward zero instead of toward minus infinity.
  assign mag_sh  = (sum[ACC_W-1] ? ACC_W'(-sum) : ACC_W'(sum)) >> FRAC_W;
  assign r_trunc = sum[ACC_W-1] ? -signed'(mag_sh) : signed'(mag_sh);
  assign r_relu  = ((RELU_EN != 0) && r_trunc[ACC_W-1]) ? '0 : r_trunc;

  always_comb begin
    sat_flag = 1'b0;
    sat_data = r_relu[DATA_W-1:0];
    if (r_relu > OUT_MAX) begin
      sat_flag = 1'b1;
      sat_data = OUT_MAX[DATA_W-1:0];
    end else if (r_relu < OUT_MIN) begin
      sat_flag = 1'b1;
      sat_data = OUT_MIN[DATA_W-1:0];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    frame_err_d = beat && (bus.in_last != (count_q == LAST_CNT));

    case (state_q)
      ACCUM: begin
        if (beat) begin
          acc_d = acc_q + prod_ext;
          if (count_q == LAST_CNT) begin
            count_d = '0;
            state_d = FINISH;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      FINISH: begin
        out_data_d  = sat_data;
        out_sat_d   = sat_flag;
        out_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // present before the edge, independent of statement order.
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with N_INPUTS=4, Q8.8; one instance with ReLU
// and one without share the same stimulus.
module tb_neuron_mac;
  localparam int DATA_W   = 16;
  localparam int FRAC_W   = 8;
  localparam int N_INPUTS = 4;
  localparam int ACC_W    = 40;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_data   = '0;
  logic [15:0] in_weight = '0;
  logic [15:0] bias      = '0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  neuron_mac_if #(.DATA_W(DATA_W)) if_r ();
  neuron_mac_if #(.DATA_W(DATA_W)) if_n ();

  assign if_r.in_valid  = in_valid;
  assign if_r.in_data   = in_data;
  assign if_r.in_weight = in_weight;
  assign if_r.in_last   = in_last;
  assign if_r.bias      = bias;
  assign if_r.out_ready = out_ready;
  assign if_n.in_valid  = in_valid;
  assign if_n.in_data   = in_data;
  assign if_n.in_weight = in_weight;
  assign if_n.in_last   = in_last;
  assign if_n.bias      = bias;
  assign if_n.out_ready = out_ready;

  neuron_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_INPUTS(N_INPUTS),
               .ACC_W(ACC_W), .RELU_EN(1)) dut_r (
    .clk(clk), .reset(reset), .bus(if_r.slave)
  );

  neuron_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_INPUTS(N_INPUTS),
               .ACC_W(ACC_W), .RELU_EN(0)) dut_n (
    .clk(clk), .reset(reset), .bus(if_n.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [15:0] w, input logic last);
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    in_last   = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] d, input logic [15:0] w);
    for (int i = 0; i < N_INPUTS; i++) send_beat(d, w, i == N_INPUTS - 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    in_valid = 1'b0;
    while (if_r.out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    vectors++;
    if (if_r.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s timeout: out_valid=%b want 1 within 10 cycles", tag, if_r.out_valid);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (if_r.in_ready !== 1'b1 || if_r.out_valid !== 1'b0 || if_r.frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset ctrl: in_ready=%b out_valid=%b frame_err=%b want 1 0 0",
               if_r.in_ready, if_r.out_valid, if_r.frame_err);
    end
    vectors++;
    if (if_r.out_data !== 16'h0000 || if_r.out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL reset data: out_data=%h out_sat=%b want 0000 0", if_r.out_data, if_r.out_sat);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    bias      = 16'h0040;
    send_frame(16'h0100, 16'h0080);
    vectors++;
    if (if_r.out_valid !== 1'b0 || if_r.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic t+1: out_valid=%b in_ready=%b want 0 0", if_r.out_valid, if_r.in_ready);
    end
    step();
    vectors++;
    if (if_r.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic t+2 valid: out_valid=%b want 1", if_r.out_valid);
    end
    vectors++;
    if (if_r.out_data !== 16'h0240 || if_r.out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL basic relu result: out_data=%h out_sat=%b want 0240 0", if_r.out_data, if_r.out_sat);
    end
    vectors++;
    if (if_n.out_data !== 16'h0240 || if_n.out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL basic signed result: out_data=%h out_sat=%b want 0240 0", if_n.out_data, if_n.out_sat);
    end
    step();
    vectors++;
    if (if_r.out_valid !== 1'b0 || if_r.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic t+3: out_valid=%b in_ready=%b want 0 1", if_r.out_valid, if_r.in_ready);
    end
  endtask

  task automatic test_round();
    bias = 16'h0000;
    send_beat(16'hFF80, 16'h0101, 1'b0);
    send_beat(16'h0000, 16'h0000, 1'b0);
    send_beat(16'h0000, 16'h0000, 1'b0);
    send_beat(16'h0000, 16'h0000, 1'b1);
    wait_valid("round");
    vectors++;
    if (if_n.out_data !== 16'hFF80 || if_n.out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL round toward zero: out_data=%h out_sat=%b want ff80 0", if_n.out_data, if_n.out_sat);
    end
    vectors++;
    if (if_r.out_data !== 16'h0000 || if_r.out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL round relu: out_data=%h out_sat=%b want 0000 0", if_r.out_data, if_r.out_sat);
    end
    accept();
  endtask

  task automatic test_saturation();
    bias = 16'h0000;
    send_frame(16'h7FFF, 16'h7FFF);
    wait_valid("sat pos");
    vectors++;
    if (if_n.out_data !== 16'h7FFF || if_n.out_sat !== 1'b1 ||
        if_r.out_data !== 16'h7FFF || if_r.out_sat !== 1'b1) begin
      miscompares++;
      $display("FAIL sat positive: n=%h/%b r=%h/%b want 7fff/1 both",
               if_n.out_data, if_n.out_sat, if_r.out_data, if_r.out_sat);
    end
    accept();
    send_frame(16'h7FFF, 16'h8001);
    wait_valid("sat neg");
    vectors++;
    if (if_n.out_data !== 16'h8000 || if_n.out_sat !== 1'b1) begin
      miscompares++;
      $display("FAIL sat negative: out_data=%h out_sat=%b want 8000 1", if_n.out_data, if_n.out_sat);
    end
    vectors++;
    if (if_r.out_data !== 16'h0000 || if_r.out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL sat negative relu: out_data=%h out_sat=%b want 0000 0", if_r.out_data, if_r.out_sat);
    end
    accept();
  endtask

  task automatic test_backpressure();
    bias      = 16'h0040;
    out_ready = 1'b0;
    send_frame(16'h0100, 16'h0080);
    wait_valid("backpressure");
    for (int i = 0; i < 10; i++) begin
      // Beats offered during HOLD must be ignored.
      in_valid  = 1'b1;
      in_data   = 16'h1234;
      in_weight = 16'h4321;
      step();
      vectors++;
      if (if_r.out_valid !== 1'b1 || if_r.out_data !== 16'h0240 || if_r.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure hold %0d: out_valid=%b out_data=%h in_ready=%b want 1 0240 0",
                 i, if_r.out_valid, if_r.out_data, if_r.in_ready);
      end
    end
    in_valid = 1'b0;
    accept();
    vectors++;
    if (if_r.out_valid !== 1'b0 || if_r.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure release: out_valid=%b in_ready=%b want 0 1", if_r.out_valid, if_r.in_ready);
    end
    bias = 16'h0000;
    send_frame(16'h0200, 16'h0100);
    wait_valid("backpressure next");
    vectors++;
    if (if_n.out_data !== 16'h0800 || if_n.out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure next frame: out_data=%h out_sat=%b want 0800 0", if_n.out_data, if_n.out_sat);
    end
    accept();
  endtask

  task automatic test_reset_midframe();
    bias = 16'h0040;
    send_beat(16'h0100, 16'h0080, 1'b0);
    send_beat(16'h0100, 16'h0080, 1'b0);
    do_reset();
    send_frame(16'h0100, 16'h0080);
    wait_valid("reset midframe");
    vectors++;
    if (if_r.out_data !== 16'h0240) begin
      miscompares++;
      $display("FAIL reset midframe: out_data=%h want 0240", if_r.out_data);
    end
    accept();
    for (int i = 0; i < N_INPUTS; i++) begin
      send_beat(16'h0100, 16'h0080, i == N_INPUTS - 1);
      step();
      if (i == 1) step();
    end
    wait_valid("gaps");
    vectors++;
    if (if_n.out_data !== 16'h0240) begin
      miscompares++;
      $display("FAIL gaps: out_data=%h want 0240", if_n.out_data);
    end
    out_ready = 1'b0;
    step();
    do_reset();
    vectors++;
    if (if_r.out_valid !== 1'b0 || if_r.in_ready !== 1'b1 || if_r.out_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset in hold: out_valid=%b in_ready=%b out_data=%h want 0 1 0000",
               if_r.out_valid, if_r.in_ready, if_r.out_data);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_frame_err();
    logic [3:0] lasts;
    logic [3:0] want;
    bias  = 16'h0040;
    lasts = 4'b0100;
    want  = 4'b1100;
    for (int i = 0; i < N_INPUTS; i++) begin
      send_beat(16'h0100, 16'h0080, lasts[i]);
      vectors++;
      if (if_r.frame_err !== want[i]) begin
        miscompares++;
        $display("FAIL frame_err beat %0d: frame_err=%b want %b", i, if_r.frame_err, want[i]);
      end
    end
    step();
    vectors++;
    if (if_r.frame_err !== 1'b0 || if_r.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_err result timing: frame_err=%b out_valid=%b want 0 1",
               if_r.frame_err, if_r.out_valid);
    end
    vectors++;
    if (if_r.out_data !== 16'h0240) begin
      miscompares++;
      $display("FAIL frame_err result: out_data=%h want 0240", if_r.out_data);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_saturation();
    test_backpressure();
    test_reset_midframe();
    test_frame_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
